// File: rtl/bcd_convert_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_convert_ctrl_if
// Request/result bundle for the signed binary to BCD converter.
//   start        : conversion request (requester -> converter)
//   signedInput  : 21-bit two's-complement operand (requester -> converter)
//   busy         : conversion in progress (converter -> requester)
//   done         : one-cycle result-valid pulse (converter -> requester)
//   sign         : last converted value was negative
//   overflow     : last magnitude exceeded 999999
//   binary1..6   : BCD digits, binary1 = ones, binary6 = hundred-thousands
// Modports: master = requester side, slave = converter side.
// ---------------------------------------------------------------------------
interface bcd_convert_ctrl_if;
    logic        start;
    logic [20:0] signedInput;
    logic        busy;
    logic        done;
    logic        sign;
    logic        overflow;
    logic [3:0]  binary1;
    logic [3:0]  binary2;
    logic [3:0]  binary3;
    logic [3:0]  binary4;
    logic [3:0]  binary5;
    logic [3:0]  binary6;

    modport master (
        output start, signedInput,
        input  busy, done, sign, overflow,
        input  binary1, binary2, binary3, binary4, binary5, binary6
    );

    modport slave (
        input  start, signedInput,
        output busy, done, sign, overflow,
        output binary1, binary2, binary3, binary4, binary5, binary6
    );
endinterface

// File: rtl/bcd_convert_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_convert_ctrl
// Converts a 21-bit two's-complement value into sign + six BCD digits using a
// serial double-dabble (one magnitude bit per clock, MSB first).
//
// Ports:
//   clk    : rising-edge clock for all state
//   reset  : synchronous, active-high reset
//   bus    : bcd_convert_ctrl_if.slave (start/signedInput in; busy, done,
//            sign, overflow, binary1..binary6 out)
//
// Sequence: IDLE accepts start and captures sign/magnitude; CONV performs 21
// add-3/shift steps; the last step's result is transferred to the output
// registers while entering DONE, which raises done for exactly one cycle.
// Results hold until the next transfer. Magnitudes above 999999 set overflow
// and force all digits to 9.
//
// Optional feature macro: BCD_LEADING_BLANK_EN
//   defined   : leading zero digits binary6..binary2 are output as 4'hF
//               (binary1 is never blanked; overflow forcing wins)
//   undefined : leading zeros are output as 4'h0, no blanking logic present
// ---------------------------------------------------------------------------
module bcd_convert_ctrl (
    input  logic                     clk,
    input  logic                     reset,
    bcd_convert_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd20;

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [20:0] shift_r;      // magnitude, consumed MSB first
    logic [27:0] bcd_r;        // 7 working BCD nibbles (millions on top)
    logic        sign_cap_r;   // sign captured with the current request
    logic        busy_r;
    logic        done_r;
    logic        sign_r;
    logic        overflow_r;
    logic [23:0] digits_r;     // {binary6, ..., binary1}

    logic [27:0] bcd_adj_s;
    logic [27:0] bcd_next_s;
    logic        ovf_s;
    logic [23:0] digits_s;

    // Two's-complement magnitude; 21'h100000 maps onto 1048576 unchanged.
    function automatic logic [20:0] magnitude(input logic [20:0] v);
        logic [20:0] m;
        if (v[20]) begin
            m = (~v) + 21'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Double-dabble correction: every nibble of 5 or more gets +3 so the
    // following shift carries correctly into the next decimal digit.
    function automatic logic [27:0] dabble_adjust(input logic [27:0] v);
        logic [27:0] r;
        for (int i = 0; i < 7; i++) begin
            if (v[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

`ifdef BCD_LEADING_BLANK_EN
    // Replace zero digits from the most significant end down to binary2 with
    // the blank code; stops at the first nonzero digit.
    function automatic logic [23:0] blank_leading(input logic [23:0] d);
        logic [23:0] r;
        logic        lead;
        r    = d;
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (lead && (d[i*4 +: 4] == 4'd0)) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`endif

    // One double-dabble step and the formatted result that step would yield.
    always_comb begin
        bcd_adj_s  = dabble_adjust(bcd_r);
        bcd_next_s = {bcd_adj_s[26:0], shift_r[20]};
        // The millions nibble never reaches 5 for a 21-bit magnitude, so its
        // carry-out is folded into overflow only as a safety net.
        ovf_s      = bcd_adj_s[27] | (bcd_next_s[27:24] != 4'd0);
        if (ovf_s) begin
            digits_s = {6{4'd9}};
        end else begin
`ifdef BCD_LEADING_BLANK_EN
            digits_s = blank_leading(bcd_next_s[23:0]);
`else
            digits_s = bcd_next_s[23:0];
`endif
        end
    end

    // Control FSM with registered busy/done and the result transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            shift_r    <= 21'd0;
            bcd_r      <= 28'd0;
            sign_cap_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sign_r     <= 1'b0;
            overflow_r <= 1'b0;
            digits_r   <= 24'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r    <= ST_CONV;
                        busy_r     <= 1'b1;
                        cnt_r      <= 5'd0;
                        sign_cap_r <= bus.signedInput[20];
                        shift_r    <= magnitude(bus.signedInput);
                        bcd_r      <= 28'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                ST_CONV: begin
                    bcd_r   <= bcd_next_s;
                    shift_r <= {shift_r[19:0], 1'b0};
                    if (cnt_r == LAST_STEP) begin
                        // Transfer uses this edge's step result directly.
                        state_r    <= ST_DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        cnt_r      <= 5'd0;
                        sign_r     <= sign_cap_r;
                        overflow_r <= ovf_s;
                        digits_r   <= digits_s;
                    end else begin
                        state_r <= ST_CONV;
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end

                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end

                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 5'd0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sign     = sign_r;
    assign bus.overflow = overflow_r;
    assign bus.binary1  = digits_r[3:0];
    assign bus.binary2  = digits_r[7:4];
    assign bus.binary3  = digits_r[11:8];
    assign bus.binary4  = digits_r[15:12];
    assign bus.binary5  = digits_r[19:16];
    assign bus.binary6  = digits_r[23:20];

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_convert_ctrl
// Scoreboard bench: each issued request pushes its hand-computed result and
// the cycle its done pulse is due; a monitor pops on every done pulse.
// ---------------------------------------------------------------------------
module tb_bcd_convert_ctrl;

    typedef struct {
        logic        sign;
        logic        ovf;
        logic [23:0] digits;
        int          done_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    bcd_convert_ctrl_if bus ();

    bcd_convert_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used for latency checks.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    function automatic logic [23:0] out_digits();
        return {bus.binary6, bus.binary5, bus.binary4,
                bus.binary3, bus.binary2, bus.binary1};
    endfunction

    // Expected digit formatting for the configured build.
    function automatic logic [23:0] fmt(input logic [23:0] d);
`ifdef BCD_LEADING_BLANK_EN
        logic [23:0] r;
        logic        lead;
        r    = d;
        lead = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (lead && d[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
        return r;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: mutual exclusion of busy/done and scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("digits", {8'd0, out_digits()}, {8'd0, e.digits});
                    chk("sign", {31'd0, bus.sign}, {31'd0, e.sign});
                    chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
                    chk("latency", cyc, e.done_cyc);
                end
            end
        end
    end

    // One request; inputs keep changing afterwards and start is poked in CONV.
    task automatic run_one(input logic [20:0] val, input logic es, input logic eo,
                           input logic [23:0] ed);
        exp_t e;
        bit   seen;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signedInput = val;
        e.sign     = es;
        e.ovf      = eo;
        e.digits   = fmt(ed);
        e.done_cyc = cyc + 22;
        sb.push_back(e);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.signedInput = ~val;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            bus.signedInput = bus.signedInput + 21'd12345;
            bus.start       = (i == 5) ? 1'b1 : 1'b0;
        end
        bus.start = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        chk("hold_digits", {8'd0, out_digits()}, {8'd0, e.digits});
        chk("hold_sign", {31'd0, bus.sign}, {31'd0, es});
        chk("hold_ovf", {31'd0, bus.overflow}, {31'd0, eo});
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main stimulus.
    initial begin
        exp_t e;
        int   k;
        int   dones;
        cyc   = 0;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start       = 1'b0;
        bus.signedInput = 21'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sign", {31'd0, bus.sign}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("rst_digits", {8'd0, out_digits()}, 32'd0);

        run_one(21'd123456,  1'b0, 1'b0, 24'h123456);
        run_one(21'h1FFFFF,  1'b1, 1'b0, 24'h000001);
        run_one(21'd999999,  1'b0, 1'b0, 24'h999999);
        run_one(21'd1000000, 1'b0, 1'b1, 24'h999999);
        run_one(21'h100000,  1'b1, 1'b1, 24'h999999);
        run_one(21'd0,       1'b0, 1'b0, 24'h000000);
        run_one(21'd1847152, 1'b1, 1'b0, 24'h250000);
        run_one(21'd42,      1'b0, 1'b0, 24'h000042);

        // Abort a conversion of 55 with reset at CONV cycle 10.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.signedInput = 21'd55;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_sign", {31'd0, bus.sign}, 32'd0);
        chk("abort_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("abort_digits", {8'd0, out_digits()}, 32'd0);
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_one(21'd7, 1'b0, 1'b0, 24'h000007);

        // start held high, input changing each cycle: accepts 500, 523, 546.
        @(negedge clk);
        k = cyc;
        for (int j = 0; j < 3; j++) begin
            e.sign     = 1'b0;
            e.ovf      = 1'b0;
            e.digits   = fmt((j == 0) ? 24'h000500 : (j == 1) ? 24'h000523 : 24'h000546);
            e.done_cyc = k + 22 + 23 * j;
            sb.push_back(e);
        end
        for (int i = 0; i < 80; i++) begin
            bus.start       = (i <= 46) ? 1'b1 : 1'b0;
            bus.signedInput = 21'd500 + 21'(i);
            @(negedge clk);
        end
        bus.start = 1'b0;

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
